// File: rtl/ccff_config_sequencer.sv
// Loads an IO-edge tile's grid IO chain then its connection-block chain from a
// valid/ready bitstream, one bit per prog_clk, and times the IO isolation release.
module ccff_config_sequencer #(
    parameter int unsigned WORD_W   = 8,
    parameter int unsigned IO_BITS  = 4,
    parameter int unsigned CB_BITS  = 20,
    parameter int unsigned ISOL_DLY = 4
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head_io,
    output logic              shift_en_io,
    output logic              ccff_head_cb,
    output logic              shift_en_cb,
    output logic              busy,
    output logic              done,
    output logic              IO_ISOL_N
);

    localparam int unsigned CHAIN_MAX = (IO_BITS > CB_BITS) ? IO_BITS : CB_BITS;
    localparam int unsigned CHAIN_W   = $clog2(CHAIN_MAX + 1);
    localparam int unsigned BCNT_W    = $clog2(WORD_W + 1);
    localparam int unsigned ISOL_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_IO = 2'd1,
        LOAD_CB = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   shreg;
    logic [BCNT_W-1:0]   buf_cnt;
    logic [CHAIN_W-1:0]  chain_cnt;
    logic [ISOL_W-1:0]   isol_cnt;
    logic                shift;
    logic                last_shift;
    logic                accept;

    assign shift      = busy && (buf_cnt != '0);
    assign last_shift = shift && (chain_cnt == CHAIN_W'(1));
    assign accept     = cfg_ready && cfg_valid;

    // State register
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; start is only honoured when not loading
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = LOAD_IO;
            LOAD_IO: if (last_shift) state_nxt = LOAD_CB;
            LOAD_CB: if (last_shift) state_nxt = DONE;
            DONE:    if (start)      state_nxt = LOAD_IO;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        cfg_ready    = 1'b0;
        shift_en_io  = 1'b0;
        ccff_head_io = 1'b0;
        shift_en_cb  = 1'b0;
        ccff_head_cb = 1'b0;
        case (state)
            LOAD_IO: begin
                busy         = 1'b1;
                cfg_ready    = (buf_cnt == '0);
                shift_en_io  = (buf_cnt != '0);
                ccff_head_io = (buf_cnt != '0) && shreg[0];
            end
            LOAD_CB: begin
                busy         = 1'b1;
                cfg_ready    = (buf_cnt == '0);
                shift_en_cb  = (buf_cnt != '0);
                ccff_head_cb = (buf_cnt != '0) && shreg[0];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Word buffer, chain counter and isolation timer
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            shreg     <= '0;
            buf_cnt   <= '0;
            chain_cnt <= '0;
            isol_cnt  <= '0;
            IO_ISOL_N <= 1'b0;
        end else if ((state_nxt == LOAD_IO) && (state != LOAD_IO)) begin
            chain_cnt <= CHAIN_W'(IO_BITS);
            buf_cnt   <= '0;
            isol_cnt  <= '0;
            IO_ISOL_N <= 1'b0;
        end else if ((state == LOAD_CB) && (state_nxt == DONE)) begin
            // leftover bits of the final word are dropped
            shreg     <= '0;
            buf_cnt   <= '0;
            chain_cnt <= '0;
            isol_cnt  <= ISOL_W'(ISOL_DLY);
        end else begin
            if (accept) begin
                shreg   <= cfg_word;
                buf_cnt <= BCNT_W'(WORD_W);
            end else if (shift) begin
                shreg   <= {1'b0, shreg[WORD_W-1:1]};
                buf_cnt <= buf_cnt - BCNT_W'(1);
                // buffer carries straight into the CB chain on the switch edge
                if (last_shift) chain_cnt <= CHAIN_W'(CB_BITS);
                else            chain_cnt <= chain_cnt - CHAIN_W'(1);
            end
            if ((state == DONE) && (isol_cnt != '0)) begin
                isol_cnt <= isol_cnt - ISOL_W'(1);
                if (isol_cnt == ISOL_W'(1)) IO_ISOL_N <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ccff_config_sequencer.md
Name: ccff_config_sequencer

Overview:
- Programming-side controller that loads the two configuration chains of one IO-edge tile: the grid IO chain first, then the connection-block chain.
- Accepts bitstream words over a valid/ready stream and serializes them one bit per prog_clk onto the chain heads. Per-chain shift enables drive the chains' prog_clk gating.
- Holds the tile's IO isolation active during configuration and releases it a fixed delay after the load completes.
- One instance per edge tile, between the bitstream fabric and the tile's ccff ports.

Parameters:
- WORD_W, 8, bitstream word width in bits.
- IO_BITS, 4, length of the grid IO configuration chain (one DIR bit per subtile).
- CB_BITS, 20, length of the connection-block configuration chain.
- ISOL_DLY, 4, prog_clk cycles from DONE entry to IO_ISOL_N release; legal range 1..255.

Ports:
- prog_clk  in  1  programming clock; sole clock.
- pReset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- cfg_word  in  WORD_W  bitstream word; bits are consumed LSB first.
- cfg_valid  in  1  cfg_word is valid.
- cfg_ready  out  1  word accepted on a cycle where cfg_valid and cfg_ready are both 1.
- ccff_head_io  out  1  serial data into the grid IO chain.
- shift_en_io  out  1  grid IO chain shifts this cycle.
- ccff_head_cb  out  1  serial data into the CB chain.
- shift_en_cb  out  1  CB chain shifts this cycle.
- busy  out  1  high in LOAD_IO or LOAD_CB.
- done  out  1  high in DONE.
- IO_ISOL_N  out  1  0 means IOs isolated; 1 means released.

Behaviour:
- Reset (pReset=0, asynchronous):
  - State goes to IDLE.
  - All counters and the word buffer clear.
  - All outputs 0, including IO_ISOL_N=0 (isolated).
  - Reset asserted mid-load aborts the load; chain contents are undefined afterwards.
- States:
  - IDLE: start moves to LOAD_IO.
  - LOAD_IO: after IO_BITS shifts, moves to LOAD_CB.
  - LOAD_CB: after CB_BITS shifts, moves to DONE.
  - DONE: start moves to LOAD_IO, i.e. a reload.
- Isolation:
  - Entering LOAD_IO from DONE drives IO_ISOL_N=0 on the same edge.
  - start in LOAD_IO or LOAD_CB is ignored.
- Word buffer:
  - Holds one WORD_W shift register plus a remaining-bit count buf_cnt (0..WORD_W).
  - cfg_ready = busy && (buf_cnt==0), combinational from registered state.
  - On accept: buffer loads cfg_word and buf_cnt=WORD_W. No shift occurs in the accept cycle, so each word costs one bubble cycle; throughput is WORD_W bits per WORD_W+1 cycles.
- Shift:
  - A shift occurs in a cycle when busy && buf_cnt>0.
  - In LOAD_IO the shift drives shift_en_io=1 and ccff_head_io=buf[0]. In LOAD_CB it drives shift_en_cb=1 and ccff_head_cb=buf[0].
  - The inactive chain's enable and head stay 0. Heads are 0 whenever not shifting.
  - Each shift right-shifts buf and decrements buf_cnt and the active chain counter.
- Chain counters:
  - Width $clog2(max(IO_BITS,CB_BITS)+1).
  - Load to IO_BITS on LOAD_IO entry and to CB_BITS on LOAD_CB entry.
  - A chain switch happens on the edge of the last shift of that chain.
- Word boundaries:
  - Words may straddle chains. Remaining buffer bits carry into LOAD_CB with no bubble.
  - Bits left in the buffer when DONE is entered are discarded; buf_cnt clears.
- Bit order: the first bit shifted into a chain ends at the flop nearest that chain's tail.
- Underflow: if buf_cnt==0 and cfg_valid=0, no shift occurs and enables stay 0 (stall); there is no timeout.
- Completion:
  - done=1 from the DONE entry edge.
  - A counter releases IO_ISOL_N=1 exactly ISOL_DLY cycles after DONE entry; it stays 1 until reset or reload.
- Total words required = ceil((IO_BITS+CB_BITS)/WORD_W).

Test Plan:
- Basic load (defaults, cfg_valid held 1, words 0xA5, 0x3C, 0xFF after start):
  - ccff_head_io sequence: 1,0,1,0.
  - ccff_head_cb sequence: 0,1,0,1, then 0,0,1,1,1,1,0,0, then eight 1s.
  - shift_en_io high for exactly 4 cycles, shift_en_cb for exactly 20; done rises after the 24th shift.
  - IO_ISOL_N rises 4 cycles after done.
- Stall: cfg_valid deasserted for 5 cycles mid-LOAD_CB -> no enable pulses during the gap; final chain bit sequences identical to the basic load.
- Straddle: the first word's bits 4..7 go to the CB chain in the cycle immediately after the last IO shift, with no bubble.
- Ignored start: start pulsed during LOAD_CB -> no state change, counts unaffected.
- Reload: start in DONE -> IO_ISOL_N drops to 0 on the same edge, busy=1, and the full sequence repeats.
- Async reset: pReset low mid-LOAD_IO between clock edges -> all outputs 0 immediately; after release, state is IDLE and cfg_ready=0.
